// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline boundary for the 64-bit RISC-V datapath.
// Captures the memory-stage outputs and performs little-endian load
// extraction with sign/zero extension. It then registers the
// writeback/forwarding bundle (valid, write enable, rd, data, misalign).
// Optional macro RETIRE_CNT_EN adds the retire_count output and its counter.
module mem_wb_stage #(
  parameter int XLEN   = 64,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic [REG_AW-1:0] rd_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   result_in,
  input  logic [XLEN-1:0]   read_data_in,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_misalign
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_count
`endif
);

  // Returns {misalign, data}. The doubleword is shifted so that the addressed
  // byte sits in lane 0, and the lane is then sign- or zero-extended. A
  // misaligned or reserved access yields zero data.
  function automatic logic [XLEN:0] load_extract(
    input logic [2:0]      f3,
    input logic [2:0]      off,
    input logic [XLEN-1:0] dword
  );
    logic [XLEN-1:0]   lane;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] w_s;
    logic               mis;
    logic [XLEN-1:0]   val;
    lane = dword >> {off, 3'b000};
    b_s  = lane[7:0];
    h_s  = lane[15:0];
    w_s  = lane[31:0];
    mis  = 1'b0;
    val  = '0;
    case (f3)
      3'b000: val = XLEN'(b_s);
      3'b100: val = XLEN'(lane[7:0]);
      3'b001: begin mis = off[0];        val = XLEN'(h_s);        end
      3'b101: begin mis = off[0];        val = XLEN'(lane[15:0]); end
      3'b010: begin mis = |off[1:0];     val = XLEN'(w_s);        end
      3'b110: begin mis = |off[1:0];     val = XLEN'(lane[31:0]); end
      3'b011: begin mis = |off;          val = dword;             end
      default: mis = 1'b1;
    endcase
    if (mis) val = '0;
    return {mis, val};
  endfunction

  // Zero-size generate guards that tie the width parameters into the
  // elaborated design. Only XLEN = 64 is a supported configuration.
  if (XLEN != 64) begin : g_xlen_unsupported
  end
  if (CNT_W < 1) begin : g_cnt_w_invalid
  end

  logic [XLEN:0]     ext_p0;
  logic              mis_p0;
  logic [XLEN-1:0]   data_p0;
  logic              we_p0;
  logic              capture_p0;

  logic              vld_p1;
  logic              we_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [XLEN-1:0]   data_p1;
  logic              mis_p1;

  assign in_ready   = ~stall;
  assign capture_p0 = in_valid & ~stall & ~flush;

  // ---- p0: load extraction, writeback select, x0 / misalign qualification
  always_comb begin
    ext_p0  = load_extract(funct3_in, result_in[2:0], read_data_in);
    mis_p0  = mem_to_reg_in & ext_p0[XLEN];
    data_p0 = mem_to_reg_in ? ext_p0[XLEN-1:0] : result_in;
    we_p0   = reg_write_in & ~mis_p0 & (rd_in != '0);
  end

  // ---- p1: writeback register. Flush beats stall, and stall beats capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
      mis_p1  <= 1'b0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      mis_p1  <= 1'b0;
    end else if (!stall) begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        we_p1   <= we_p0;
        rd_p1   <= rd_in;
        data_p1 <= data_p0;
        mis_p1  <= mis_p0;
      end else begin
        we_p1   <= 1'b0;
        mis_p1  <= 1'b0;
      end
    end
  end

  assign wb_valid     = vld_p1;
  assign wb_reg_write = we_p1;
  assign wb_rd        = rd_p1;
  assign wb_data      = data_p1;
  assign wb_misalign  = mis_p1;

`ifdef RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt_p1;

  // Count each captured entry that is not a misaligned or reserved load.
  // The counter wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_p1 <= '0;
    end else if (capture_p0 && !mis_p0) begin
      retire_cnt_p1 <= retire_cnt_p1 + 1'b1;
    end
  end

  assign retire_count = retire_cnt_p1;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: bench for mem_wb_stage. It uses directed table vectors,
// hand-written stall/flush/reset sequences, and randomized cycles checked
// against a byte-level reference model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, stall, flush;
  logic        mem_to_reg_in, reg_write_in;
  logic [4:0]  rd_in;
  logic [2:0]  funct3_in;
  logic [63:0] result_in, read_data_in;
  logic        wb_valid, wb_reg_write, wb_misalign;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
`ifdef RETIRE_CNT_EN
  logic [63:0] retire_count;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .rd_in(rd_in), .funct3_in(funct3_in),
    .result_in(result_in), .read_data_in(read_data_in),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_misalign(wb_misalign)
`ifdef RETIRE_CNT_EN
    , .retire_count(retire_count)
`endif
  );

  typedef struct {
    logic        m2r;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [63:0] res;
    logic [63:0] rdat;
    logic        e_we;
    logic [63:0] e_data;
    logic        e_mis;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m2r, input logic rw, input logic [4:0] rd,
                       input logic [2:0] f3, input logic [63:0] res, input logic [63:0] rdat);
    in_valid = v; mem_to_reg_in = m2r; reg_write_in = rw; rd_in = rd;
    funct3_in = f3; result_in = res; read_data_in = rdat;
  endtask

  // Reference model: picks 2^f3[1:0] bytes starting at the offset, then
  // applies the alignment rule and the sign rule byte by byte.
  function automatic void ref_wb(input logic m2r, input logic rw, input logic [4:0] rd,
                                 input logic [2:0] f3, input logic [63:0] res,
                                 input logic [63:0] rdat, output logic we,
                                 output logic [63:0] data, output logic mis);
    int size;
    int off;
    size = 1 << f3[1:0];
    off  = int'(res[2:0]);
    mis  = 1'b0;
    data = 64'd0;
    if (!m2r) begin
      data = res;
    end else if (f3 == 3'b111 || (off % size) != 0) begin
      mis = 1'b1;
    end else begin
      for (int i = 0; i < size; i++)
        data = data | (64'(rdat[8*(off+i) +: 8]) << (8*i));
      if (!f3[2] && data[8*size-1])
        for (int i = size; i < 8; i++) data = data | (64'hFF << (8*i));
    end
    we = rw && !mis && (rd != 5'd0);
  endfunction

  localparam logic [63:0] RD = 64'h8877_6655_4433_2211;

  vec_t vecs[10];

  logic        e_vld, e_we, e_mis, m_we, m_mis;
  logic [4:0]  e_rd;
  logic [63:0] e_data, m_data;
  logic        r_v, r_s, r_f;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 5'd5,  3'b000, 64'h1234_5678_9ABC_DEF0, RD, 1'b1, 64'h1234_5678_9ABC_DEF0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 5'd6,  3'b000, 64'h1007, RD, 1'b1, 64'hFFFF_FFFF_FFFF_FF88, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 5'd6,  3'b100, 64'h1007, RD, 1'b1, 64'h0000_0000_0000_0088, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 5'd7,  3'b001, 64'h1006, RD, 1'b1, 64'hFFFF_FFFF_FFFF_8877, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 5'd8,  3'b110, 64'h1004, RD, 1'b1, 64'h0000_0000_8877_6655, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 5'd9,  3'b011, 64'h1000, RD, 1'b1, 64'h8877_6655_4433_2211, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 5'd10, 3'b010, 64'h1002, RD, 1'b0, 64'h0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, 5'd0,  3'b000, 64'hDEAD_BEEF, RD, 1'b0, 64'hDEAD_BEEF, 1'b0};
    vecs[8] = '{1'b1, 1'b1, 5'd11, 3'b111, 64'h1000, RD, 1'b0, 64'h0, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 5'd12, 3'b101, 64'h1001, RD, 1'b0, 64'h0, 1'b1};

    // Reset state; in_ready follows ~stall even while reset is held.
    rst_n = 1'b0; stall = 1'b1; flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 3'd0, 64'd0, 64'd0);
    #2;
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_valid", 64'(wb_valid), 64'd0);
    check("reset_data", wb_data, 64'd0);
    stall = 1'b0;
    #1;
    check("reset_in_ready_nostall", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_empty_valid", 64'(wb_valid), 64'd0);

    // Directed table.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].m2r, vecs[i].rw, vecs[i].rd, vecs[i].f3, vecs[i].res, vecs[i].rdat);
      step();
      check($sformatf("vec%0d_valid", i), 64'(wb_valid), 64'd1);
      check($sformatf("vec%0d_we", i), 64'(wb_reg_write), 64'(vecs[i].e_we));
      check($sformatf("vec%0d_rd", i), 64'(wb_rd), 64'(vecs[i].rd));
      check($sformatf("vec%0d_data", i), wb_data, vecs[i].e_data);
      check($sformatf("vec%0d_mis", i), 64'(wb_misalign), 64'(vecs[i].e_mis));
    end

    // Empty cycle after a writing entry.
    drive(1'b0, 1'b0, 1'b1, 5'd3, 3'd0, 64'h55, 64'd0);
    step();
    check("empty_valid", 64'(wb_valid), 64'd0);
    check("empty_we", 64'(wb_reg_write), 64'd0);

    // Stall hold, then flush together with stall.
    drive(1'b1, 1'b0, 1'b1, 5'd7, 3'd0, 64'hAAAA_0000_BBBB_1111, 64'd0);
    step();
    drive(1'b1, 1'b0, 1'b1, 5'd9, 3'd0, 64'h0000_CCCC_0000_DDDD, 64'd0);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      check($sformatf("stall%0d_in_ready", c), 64'(in_ready), 64'd0);
      step();
      check($sformatf("stall%0d_valid", c), 64'(wb_valid), 64'd1);
      check($sformatf("stall%0d_rd", c), 64'(wb_rd), 64'd7);
      check($sformatf("stall%0d_data", c), wb_data, 64'hAAAA_0000_BBBB_1111);
    end
    flush = 1'b1;
    step();
    check("flush_stall_valid", 64'(wb_valid), 64'd0);
    check("flush_stall_we", 64'(wb_reg_write), 64'd0);
    check("flush_stall_mis", 64'(wb_misalign), 64'd0);
    stall = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd4, 3'b010, 64'h1002, RD);
    step();
    check("flush_capture_valid", 64'(wb_valid), 64'd0);
    check("flush_capture_mis", 64'(wb_misalign), 64'd0);
    flush = 1'b0;

    // Asynchronous reset while outputs are nonzero.
    drive(1'b1, 1'b0, 1'b1, 5'd5, 3'd0, 64'h1234_5678_9ABC_DEF0, 64'd0);
    step();
    check("pre_areset_valid", 64'(wb_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_valid", 64'(wb_valid), 64'd0);
    check("areset_we", 64'(wb_reg_write), 64'd0);
    check("areset_rd", 64'(wb_rd), 64'd0);
    check("areset_data", wb_data, 64'd0);
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    step();

`ifdef RETIRE_CNT_EN
    // 3 good captures, 1 flushed, 1 misaligned, then stall/empty cycles.
    check("cnt_start", retire_count, 64'd0);
    drive(1'b1, 1'b0, 1'b1, 5'd1, 3'd0, 64'd1, 64'd0); step();
    drive(1'b1, 1'b1, 1'b1, 5'd2, 3'b011, 64'h1000, RD); step();
    flush = 1'b1; step(); flush = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 5'd3, 3'b010, 64'h1002, RD); step();
    drive(1'b1, 1'b0, 1'b1, 5'd0, 3'd0, 64'd9, 64'd0); step();
    stall = 1'b1; step(); stall = 1'b0;
    in_valid = 1'b0; step();
    check("cnt_three", retire_count, 64'd3);
`endif

    // Randomized cycles against the reference model (from a known empty state).
    e_vld = 1'b0; e_we = 1'b0; e_mis = 1'b0; e_rd = '0; e_data = '0;
    for (int n = 0; n < 300; n++) begin
      r_v = ($urandom_range(3) != 0);
      r_s = ($urandom_range(3) == 0);
      r_f = ($urandom_range(6) == 0);
      drive(r_v, 1'($urandom_range(1)), 1'($urandom_range(1)), 5'($urandom_range(31)),
            3'($urandom_range(7)), {$urandom(), $urandom()}, {$urandom(), $urandom()});
      stall = r_s; flush = r_f;
      #1;
      check("rand_in_ready", 64'(in_ready), 64'(!r_s));
      ref_wb(mem_to_reg_in, reg_write_in, rd_in, funct3_in, result_in, read_data_in,
             m_we, m_data, m_mis);
      if (r_f) begin
        e_vld = 1'b0; e_we = 1'b0; e_mis = 1'b0;
      end else if (!r_s) begin
        e_vld = r_v;
        if (r_v) begin
          e_we = m_we; e_rd = rd_in; e_data = m_data; e_mis = m_mis;
        end else begin
          e_we = 1'b0;
        end
      end
      step();
      check("rand_valid", 64'(wb_valid), 64'(e_vld));
      check("rand_we", 64'(wb_reg_write), 64'(e_we));
      if (e_vld) begin
        check("rand_rd", 64'(wb_rd), 64'(e_rd));
        check("rand_data", wb_data, e_data);
        check("rand_mis", 64'(wb_misalign), 64'(e_mis));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Watchdog: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
